// File: rtl/demux_1to2_stream_pkg.sv
// demux_1to2_stream_pkg: channel select encodings and counter width shared by the demux files
package demux_1to2_stream_pkg;
  localparam logic SEL_CH0 = 1'b0;
  localparam logic SEL_CH1 = 1'b1;
  localparam int DEMUX_CNT_W = 16;
endpackage

// File: rtl/demux_out_stage.sv
// demux_out_stage: one-entry valid/ready output register with optional transfer counter
//   clk, rst        clock, async active-high reset
//   load            accept d this edge (only asserted by the parent when free)
//   d               incoming word
//   ready           downstream consumer accepts
//   valid, data     held word and its presence flag
//   free            stage can take a word this cycle (empty or draining)
//   count           completed handshakes, wraps (only with DEMUX_COUNT_EN)
module demux_out_stage
  import demux_1to2_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
`ifdef DEMUX_COUNT_EN
  ,
  output logic [DEMUX_CNT_W-1:0] count
`endif
);
  assign free = ~valid | ready;
  // data only moves on load, so a held word stays stable until its handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (load) data <= d;
      valid <= load | (valid & ~ready);
    end
  end
`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (valid & ready) count <= count + 1'b1;
  end
`endif
endmodule

// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream: registered 1-to-2 stream demux, latency 1, steered by InSel
//   Clk, Reset                 clock, async active-high reset
//   InData, InSel, InValid     input word, destination (0 -> ch0, 1 -> ch1), presence
//   InReady                    selected channel can accept this cycle
//   Out0Data/Valid/Ready       ch0 (register-file write-back)
//   Out1Data/Valid/Ready       ch1 (HI/LO / store path)
//   Out0Count, Out1Count       per-channel handshake counters, present only with DEMUX_COUNT_EN
module demux_1to2_stream
  import demux_1to2_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] InData,
  input  logic             InSel,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Out0Data,
  output logic             Out0Valid,
  input  logic             Out0Ready,
  output logic [WIDTH-1:0] Out1Data,
  output logic             Out1Valid,
  input  logic             Out1Ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [DEMUX_CNT_W-1:0] Out0Count,
  output logic [DEMUX_CNT_W-1:0] Out1Count
`endif
);
  logic ch0_free, ch1_free, acc0, acc1;
  assign InReady = (InSel == SEL_CH1) ? ch1_free : ch0_free;
  // InValid gates first so an unknown InSel while idle cannot reach the stages
  assign acc0 = InValid & (InSel == SEL_CH0) & ch0_free;
  assign acc1 = InValid & (InSel == SEL_CH1) & ch1_free;
  demux_out_stage #(.WIDTH(WIDTH)) u_ch0 (
    .clk(Clk), .rst(Reset), .load(acc0), .d(InData), .ready(Out0Ready),
    .valid(Out0Valid), .data(Out0Data), .free(ch0_free)
`ifdef DEMUX_COUNT_EN
    , .count(Out0Count)
`endif
  );
  demux_out_stage #(.WIDTH(WIDTH)) u_ch1 (
    .clk(Clk), .rst(Reset), .load(acc1), .d(InData), .ready(Out1Ready),
    .valid(Out1Valid), .data(Out1Data), .free(ch1_free)
`ifdef DEMUX_COUNT_EN
    , .count(Out1Count)
`endif
  );
endmodule

// File: tb/tb_demux_1to2_stream.sv
// tb_demux_1to2_stream: directed scoreboard bench for demux_1to2_stream
module tb_demux_1to2_stream;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] in_data, out0_data, out1_data;
  logic in_sel, in_valid, in_ready;
  logic out0_valid, out0_ready, out1_valid, out1_ready;
`ifdef DEMUX_COUNT_EN
  logic [15:0] out0_count, out1_count;
`endif
  logic [15:0] m_c0, m_c1;
  logic m_v0, m_v1;
  logic [31:0] q0[$], q1[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  demux_1to2_stream #(.WIDTH(32)) dut (
    .Clk(clk), .Reset(rst), .InData(in_data), .InSel(in_sel), .InValid(in_valid),
    .InReady(in_ready), .Out0Data(out0_data), .Out0Valid(out0_valid), .Out0Ready(out0_ready),
    .Out1Data(out1_data), .Out1Valid(out1_valid), .Out1Ready(out1_ready)
`ifdef DEMUX_COUNT_EN
    , .Out0Count(out0_count), .Out1Count(out1_count)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    q0.delete();
    q1.delete();
    m_v0 = 1'b0;
    m_v1 = 1'b0;
    m_c0 = '0;
    m_c1 = '0;
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_v0"}, 32'(out0_valid), 32'd0);
    chk({tag, "_v1"}, 32'(out1_valid), 32'd0);
    chk({tag, "_d0"}, out0_data, 32'd0);
    chk({tag, "_d1"}, out1_data, 32'd0);
`ifdef DEMUX_COUNT_EN
    chk({tag, "_c0"}, 32'(out0_count), 32'd0);
    chk({tag, "_c1"}, 32'(out1_count), 32'd0);
`endif
  endtask
  // one clock cycle: drive after the falling edge, check against the model, then advance it
  task automatic cyc(input logic v, input logic s, input logic [31:0] d, input logic r0, input logic r1);
    logic rdy, a0, a1;
    @(negedge clk);
    in_valid = v;
    in_sel = s;
    in_data = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    chk("out0_valid", 32'(out0_valid), 32'(m_v0));
    chk("out1_valid", 32'(out1_valid), 32'(m_v1));
    if (m_v0 && q0.size() > 0) chk("out0_data", out0_data, q0[0]);
    if (m_v1 && q1.size() > 0) chk("out1_data", out1_data, q1[0]);
`ifdef DEMUX_COUNT_EN
    chk("out0_count", 32'(out0_count), 32'(m_c0));
    chk("out1_count", 32'(out1_count), 32'(m_c1));
`endif
    rdy = s ? (!m_v1 || r1) : (!m_v0 || r0);
    if (!$isunknown(s)) chk("in_ready", 32'(in_ready), 32'(rdy));
    a0 = v && (s === 1'b0) && rdy;
    a1 = v && (s === 1'b1) && rdy;
    if (m_v0 && r0) begin m_c0++; void'(q0.pop_front()); end
    if (m_v1 && r1) begin m_c1++; void'(q1.pop_front()); end
    if (a0) q0.push_back(d);
    if (a1) q1.push_back(d);
    m_v0 = a0 || (m_v0 && !r0);
    m_v1 = a1 || (m_v1 && !r1);
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = 1'b0;
    in_data = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    model_clear();
    #1;
    chk_reset_state("por");
    @(negedge clk);
    rst = 1'b0;
    // back-to-back stream on ch0
    cyc(1'b1, 1'b0, 32'h1111, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'h2222, 1'b1, 1'b0);
    chk("t2_first", out0_data, 32'h1111);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t2_second", out0_data, 32'h2222);
    chk("t2_ch1_idle", 32'(out1_valid), 32'd0);
    // backpressure on ch0, steer around it to ch1
    cyc(1'b1, 1'b0, 32'h3333, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h4444, 1'b0, 1'b0);
    chk("t3_blocked", 32'(in_ready), 32'd0);
    cyc(1'b1, 1'b1, 32'hABCD, 1'b0, 1'b0);
    chk("t3_other_ready", 32'(in_ready), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t3_ch1", out1_data, 32'hABCD);
    chk("t3_ch0_held", out0_data, 32'h3333);
    // drain and accept on ch1 in the same cycle
    cyc(1'b1, 1'b1, 32'h5, 1'b0, 1'b1);
    chk("t4_ready", 32'(in_ready), 32'd1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t4_valid", 32'(out1_valid), 32'd1);
    chk("t4_data", out1_data, 32'h5);
    // idle input with toggling / unknown select must not disturb held words
    for (int i = 0; i < 10; i++) cyc(1'b0, (i % 3 == 0) ? 1'bx : 1'(i), 32'hDEAD, 1'b0, 1'b0);
    chk("t5_d0", out0_data, 32'h3333);
    chk("t5_d1", out1_data, 32'h5);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("drained_v0", 32'(out0_valid), 32'd0);
    chk("drained_d0", out0_data, 32'h3333);
    // asynchronous reset with words held
    cyc(1'b1, 1'b0, 32'h7777, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h8888, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
`ifdef DEMUX_COUNT_EN
    // 65536 ch0 handshakes wrap the counter to zero; ch1 stays untouched
    for (int i = 0; i < 65536; i++) cyc(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("t6_wrap", 32'(out0_count), 32'd0);
    chk("t6_ch1", 32'(out1_count), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
